// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO fabric: FSM state encoding, bus widths,
// the data value returned with an error response, and the write-lane mask
// helper.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } mmio_state_e;

  localparam int MMIO_DW    = 32;
  localparam int MMIO_SW    = 4;
  localparam int MMIO_IDX_W = 4;

  localparam logic [MMIO_DW-1:0] MMIO_ERR_RDATA = 32'h0;

  // Zero every byte lane whose strobe is clear so slaves never see stale
  // bytes on lanes they are not meant to write.
  function automatic logic [MMIO_DW-1:0] mmio_lane_mask(
    input logic [MMIO_SW-1:0] strb,
    input logic [MMIO_DW-1:0] data
  );
    logic [MMIO_DW-1:0] masked;
    masked = '0;
    for (int b = 0; b < MMIO_SW; b++) begin
      masked[8*b +: 8] = strb[b] ? data[8*b +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder for the MMIO fabric.
// Splits the master address into a slave window index and a window offset,
// and flags a hit only for aligned addresses inside the NUM_SLV windows.
// Ports:
//   addr   in  32  master byte address
//   hit    out 1   address is aligned and falls inside a slave window
//   idx    out 4   window index (meaningful only when hit=1)
//   offset out 32  address relative to the window base
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int          NUM_SLV   = 5,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          WIN_BITS  = 12
) (
  input  logic [31:0]           addr,
  output logic                  hit,
  output logic [MMIO_IDX_W-1:0] idx,
  output logic [31:0]           offset
);

  logic [31:0] rel;
  logic [31:0] win;

  // The window number is compared at full width so that addresses far
  // above the last window cannot alias back into a valid index. Addresses
  // below BASE_ADDR wrap in the subtraction and are rejected explicitly.
  always_comb begin
    rel    = addr - BASE_ADDR;
    win    = rel >> WIN_BITS;
    hit    = (addr >= BASE_ADDR) && (win < 32'(NUM_SLV)) && (addr[1:0] == 2'b00);
    idx    = win[MMIO_IDX_W-1:0];
    offset = rel & ((32'd1 << WIN_BITS) - 32'd1);
  end

endmodule

// File: rtl/mmio_fabric.sv
// Single-master MMIO interconnect. Decodes NUM_SLV equal address windows
// starting at BASE_ADDR, runs one transaction at a time and returns a
// registered one-cycle response. Misaligned or out-of-range addresses get
// an error response without touching any slave.
// Optional feature: define MMIO_TIMEOUT_EN to abort a request with an error
// response when the selected slave stays silent for TIMEOUT cycles.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   addr, wdata_in       master address / write data
//   wstrb, we, valid     master strobes, write enable, request
//   rdata, ready, err    registered response (ready is a one-cycle pulse)
//   s_valid              one-hot request to the slaves
//   s_addr, s_wdata      window offset and lane-masked write data
//   s_wstrb, s_we        registered strobes and write enable
//   s_rdata, s_ready     per-slave read data and completion pulses
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter int          NUM_SLV   = 5,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          WIN_BITS  = 12,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata_in,
  input  logic [3:0]             wstrb,
  input  logic                   we,
  input  logic                   valid,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic [NUM_SLV-1:0]     s_valid,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_wstrb,
  output logic                   s_we,
  input  logic [32*NUM_SLV-1:0]  s_rdata,
  input  logic [NUM_SLV-1:0]     s_ready
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT < 1) begin : g_param_check
    $error("mmio_fabric: NUM_SLV must be 1..16 and TIMEOUT at least 1");
  end

  mmio_state_e state, next_state;

  logic                  dec_hit;
  logic [MMIO_IDX_W-1:0] dec_idx;
  logic [31:0]           dec_offset;
  logic [NUM_SLV-1:0]    dec_onehot;
  logic [MMIO_IDX_W-1:0] idx_q;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  timeout_hit;

  mmio_addr_decode #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .WIN_BITS  (WIN_BITS)
  ) u_decode (
    .addr   (addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  // Slave selection: the one-hot strobe for the incoming request, and the
  // completion/data mux for the slave latched at request time. Completion
  // pulses from every other slave are dropped here.
  always_comb begin
    dec_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_onehot[i] = (dec_idx == i[MMIO_IDX_W-1:0]);
      if (idx_q == i[MMIO_IDX_W-1:0]) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  // Counts REQ cycles; held at zero everywhere else so each request starts
  // from a clean count. The abort fires on the TIMEOUT-th silent cycle.
  always_ff @(posedge clk) begin
    if (rst || state != REQ) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == REQ) && (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A slave completion in the same cycle as a timeout
  // wins, since its data is valid.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (valid) next_state = dec_hit ? REQ : ERR;
      REQ:  if (sel_ready || timeout_hit) next_state = RESP;
      ERR:  next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. The request is captured when IDLE accepts it; the
  // response is loaded on the transition into RESP so ready is high for
  // exactly the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      s_valid <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      s_we    <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            idx_q   <= dec_idx;
            s_addr  <= dec_offset;
            s_wdata <= mmio_lane_mask(wstrb, wdata_in);
            s_wstrb <= wstrb;
            s_we    <= we;
            if (dec_hit) begin
              s_valid <= dec_onehot;
            end
          end
        end
        REQ: begin
          if (sel_ready) begin
            s_valid <= '0;
            ready   <= 1'b1;
            err     <= 1'b0;
            rdata   <= s_we ? '0 : sel_rdata;
          end else if (timeout_hit) begin
            s_valid <= '0;
            ready   <= 1'b1;
            err     <= 1'b1;
            rdata   <= MMIO_ERR_RDATA;
          end
        end
        ERR: begin
          ready <= 1'b1;
          err   <= 1'b1;
          rdata <= MMIO_ERR_RDATA;
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_fabric.sv
// Self-checking bench for mmio_fabric: directed cases for the documented
// scenarios plus randomized requests compared against an address-map model.
module tb_mmio_fabric;

  localparam int          NSLV = 5;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          WINB = 12;
  localparam int          TO   = 8;

  logic                 clk;
  logic                 rst;
  logic [31:0]          addr;
  logic [31:0]          wdata_in;
  logic [3:0]           wstrb;
  logic                 we;
  logic                 valid;
  logic [31:0]          rdata;
  logic                 ready;
  logic                 err;
  logic [NSLV-1:0]      s_valid;
  logic [31:0]          s_addr;
  logic [31:0]          s_wdata;
  logic [3:0]           s_wstrb;
  logic                 s_we;
  logic [32*NSLV-1:0]   s_rdata;
  logic [NSLV-1:0]      s_ready;

  int checks;
  int failures;

  mmio_fabric #(
    .NUM_SLV   (NSLV),
    .BASE_ADDR (BASE),
    .WIN_BITS  (WINB),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata_in (wdata_in),
    .wstrb    (wstrb),
    .we       (we),
    .valid    (valid),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_we     (s_we),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Address map from plain arithmetic on 64-bit integers.
  function automatic void model(input logic [31:0] a, output bit hit, output int idx, output logic [31:0] off);
    longint unsigned a64, rel, slot;
    hit = 1'b0;
    idx = 0;
    off = 32'h0;
    a64 = longint'(a);
    if (a64 >= longint'(BASE) && (a64 % 4) == 0) begin
      rel  = a64 - longint'(BASE);
      slot = rel / (64'd1 << WINB);
      off  = 32'(rel % (64'd1 << WINB));
      if (slot < NSLV) begin
        hit = 1'b1;
        idx = int'(slot);
      end
    end
  endfunction

  // stray: 0 none, 1 random other slaves, 2 every other slave
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               input logic w, input int lat, input bit drop, input int stray,
                               input logic [31:0] sd);
    bit              hit;
    int              idx;
    logic [31:0]     off;
    logic [31:0]     exp_rd;
    logic [31:0]     lane_mask;
    logic [NSLV-1:0] exp_sv;
    int              edges;
    int              req_cycles;
    bit              got;
    model(a, hit, idx, off);
    exp_sv = hit ? (NSLV'(1) << idx) : '0;
    for (int i = 0; i < NSLV; i++) s_rdata[32*i +: 32] = $urandom;
    if (hit) s_rdata[32*idx +: 32] = sd;
    exp_rd = (hit && !w) ? sd : 32'h0;
    lane_mask = 32'h0;
    for (int b = 0; b < 4; b++) if (ws[b]) lane_mask = lane_mask | (32'hFF << (8*b));

    @(negedge clk);
    addr = a; wdata_in = wd; wstrb = ws; we = w; valid = 1'b1;
    edges = 0; req_cycles = 0; got = 1'b0;
    while (!got && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      s_ready = '0;
      if (stray == 1) s_ready = NSLV'($urandom) & ~exp_sv;
      if (stray == 2) s_ready = ~exp_sv;
      if (drop && edges == 1) valid = 1'b0;
      if (ready) begin
        got = 1'b1;
        valid = 1'b0;
        checkOutput("latency", edges, hit ? 2 + lat : 2);
        checkOutput("err", {31'b0, err}, {31'b0, !hit});
        checkOutput("rdata", rdata, exp_rd);
        checkOutput("s_valid_in_resp", {27'b0, s_valid}, 32'h0);
      end else begin
        checkOutput("s_valid", {27'b0, s_valid}, {27'b0, exp_sv});
        if (hit) begin
          if (req_cycles == 0) begin
            checkOutput("s_addr", s_addr, off);
            checkOutput("s_wdata", s_wdata, wd & lane_mask);
            checkOutput("s_we", {31'b0, s_we}, {31'b0, w});
            if (w) checkOutput("s_wstrb", {28'b0, s_wstrb}, {28'b0, ws});
          end
          if (req_cycles == lat) s_ready = s_ready | exp_sv;
          req_cycles++;
        end
      end
    end
    checkOutput("got_ready", {31'b0, got}, 32'h1);
    s_ready = '0;
    valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_pulse_width", {31'b0, ready}, 32'h0);
  endtask

  task automatic applyTimeoutCase();
    logic [NSLV-1:0] exp_sv;
    int              sv_cycles;
    int              ready_cnt;
    int              edges;
    bit              got;
    exp_sv = NSLV'(1) << 2;
    s_ready = '0;
    @(negedge clk);
    addr = 32'h4000_2000; wdata_in = 32'h0; wstrb = 4'h0; we = 1'b0; valid = 1'b1;
    sv_cycles = 0; ready_cnt = 0; edges = 0; got = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    while (!got && edges < 64) begin
      @(posedge clk); #1;
      edges++;
      if (ready) begin
        got = 1'b1;
        valid = 1'b0;
      end else if (s_valid == exp_sv) begin
        sv_cycles++;
      end
    end
    checkOutput("to_got_ready", {31'b0, got}, 32'h1);
    checkOutput("to_s_valid_cycles", sv_cycles, TO);
    checkOutput("to_latency", edges, TO + 1);
    checkOutput("to_err", {31'b0, err}, 32'h1);
    checkOutput("to_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    s_ready = exp_sv;
    @(posedge clk); #1;
    s_ready = '0;
    checkOutput("to_late_ready_ignored", {31'b0, ready}, 32'h0);
    checkOutput("to_late_s_valid", {27'b0, s_valid}, 32'h0);
`else
    repeat (1000) begin
      @(posedge clk); #1;
      if (ready) ready_cnt++;
      if (s_valid == exp_sv) sv_cycles++;
    end
    checkOutput("noto_ready_count", ready_cnt, 0);
    checkOutput("noto_s_valid_cycles", sv_cycles, 1000);
    valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("noto_s_valid_after_rst", {27'b0, s_valid}, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    addr = 32'h0; wdata_in = 32'h0; wstrb = 4'h0; we = 1'b0; valid = 1'b0;
    s_rdata = '0; s_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_ready", {31'b0, ready}, 32'h0);
    checkOutput("rst_err", {31'b0, err}, 32'h0);
    checkOutput("rst_s_valid", {27'b0, s_valid}, 32'h0);
    checkOutput("rst_s_addr", s_addr, 32'h0);
    checkOutput("rst_s_wdata", s_wdata, 32'h0);
    checkOutput("rst_s_wstrb", {28'b0, s_wstrb}, 32'h0);
    checkOutput("rst_s_we", {31'b0, s_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(32'h4000_4010, 32'hAABB_CCDD, 4'b0011, 1'b1, 0, 1'b0, 0, 32'h0);
    applyStimulus(32'h4000_1004, 32'h0, 4'h0, 1'b0, 4, 1'b0, 0, 32'h1234_5678);
    applyStimulus(32'h4000_5000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, 32'hDEAD_BEEF);
    applyStimulus(32'h3FFF_FFFC, 32'h0, 4'h0, 1'b0, 0, 1'b0, 0, 32'hDEAD_BEEF);
    applyStimulus(32'h4000_0002, 32'h0, 4'h0, 1'b0, 0, 1'b0, 2, 32'hDEAD_BEEF);
    applyStimulus(32'h4000_0000, 32'h0, 4'h0, 1'b0, 3, 1'b0, 2, 32'hCAFE_F00D);
    applyStimulus(32'h4000_4FFC, 32'h0, 4'h0, 1'b0, 1, 1'b1, 1, 32'h0BAD_F00D);
    applyStimulus(32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1, 32'h5555_AAAA);

    $display("[TB] silent slave");
    applyTimeoutCase();

    $display("[TB] reset during REQ");
    @(negedge clk);
    addr = 32'h4000_3008; we = 1'b0; wstrb = 4'h0; valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_s_valid_before", {27'b0, s_valid}, 32'h8);
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_s_valid", {27'b0, s_valid}, 32'h0);
    checkOutput("midrst_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_no_response", {31'b0, ready}, 32'h0);
    applyStimulus(32'h4000_3008, 32'h0, 4'h0, 1'b0, 2, 1'b0, 0, 32'h7777_1111);

    $display("[TB] randomized requests");
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: a = BASE + 32'($urandom_range(0, NSLV - 1)) * 32'd4096 + 32'($urandom_range(0, 1023)) * 32'd4;
        3:       a = BASE + 32'($urandom_range(0, NSLV - 1)) * 32'd4096 + 32'($urandom_range(0, 1023)) * 32'd4
                   + 32'($urandom_range(1, 3));
        4:       a = BASE + 32'(NSLV) * 32'd4096 + 32'($urandom_range(0, 4095)) * 32'd4;
        default: a = $urandom & 32'hFFFF_FFFC;
      endcase
      applyStimulus(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 5),
                    1'($urandom), int'($urandom_range(0, 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
